// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: pipeline control in, instruction-memory handshake, IF/ID outputs.
// Master is the fetch stage; slave is the pipeline/memory side.
interface if_fetch_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction;
    logic        if_valid;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
        output imem_req, imem_addr, PC_out, Instruction, if_valid
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
        input  imem_req, imem_addr, PC_out, Instruction, if_valid
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns PC, one outstanding imem fetch, presents {PC+4, instr} to IF/ID.
// Latency: imem latency + 0 to outputs; freeze holds the presented instruction in a buffer.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_if.master    fif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] buf_q, buf_d;

    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = fif.branch_addr & ~32'd3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        buf_d   = buf_q;
        req     = 1'b0;
        valid   = 1'b0;
        instr   = 32'h0;
        pc_out  = pc_plus4;

        if (fif.branch_taken) begin
            // Redirect beats freeze and ack; anything in flight or buffered is stale.
            pc_d = br_target;
            case (state_q)
                S_REQ: begin
                    req     = 1'b1;
                    drop_d  = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (fif.imem_ack) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD: begin
                    buf_d   = 32'h0;
                    state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (fif.imem_ack) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            valid = 1'b1;
                            instr = fif.imem_rdata;
                            if (fif.freeze) begin
                                buf_d   = fif.imem_rdata;
                                state_d = S_HOLD;
                            end else begin
                                pc_d    = pc_plus4;
                                state_d = S_REQ;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    valid = 1'b1;
                    instr = buf_q;
                    if (!fif.freeze) begin
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        if (!rst) begin
            req    = 1'b0;
            valid  = 1'b0;
            instr  = 32'h0;
            pc_out = 32'h0;
        end
    end

    assign fif.imem_req    = req;
    assign fif.imem_addr   = pc_q;
    assign fif.if_valid    = valid;
    assign fif.Instruction = instr;
    assign fif.PC_out      = pc_out;

endmodule
